// File: rtl/ddr_req_arbiter.sv
// Round-robin arbiter that shares one DDR burst channel among four cache requesters.
// It latches one request, issues its burst command, waits for completion or a watchdog abort, then pulses done.
module ddr_req_arbiter #(
  parameter int unsigned DDR_ADDR_WIDTH = 28,
  parameter int unsigned LEN_WIDTH      = 10,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_WIDTH       = 13
) (
  input  logic                              mem_clk,
  input  logic                              rst,
  input  logic                              ddr_rdy,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DDR_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]      req_len,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [NUM_REQ-1:0]                done,
  output logic                              busy,
  output logic                              cmd_valid,
  output logic [1:0]                        cmd_type,
  output logic [DDR_ADDR_WIDTH-1:0]         cmd_addr,
  output logic [LEN_WIDTH-1:0]              cmd_len,
  input  logic                              cmd_ack,
  input  logic                              burst_finish,
  output logic                              timeout_err
);

  localparam int unsigned IDX_W = 2;
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d;
  logic [NUM_REQ-1:0]        done_q, done_d;
  logic                      busy_q, busy_d;
  logic                      cmd_valid_q, cmd_valid_d;
  logic [IDX_W-1:0]          cmd_type_q, cmd_type_d;
  logic [DDR_ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_WIDTH-1:0]      cmd_len_q, cmd_len_d;
  logic                      timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [TO_WIDTH-1:0]       wd_q, wd_d;

  logic [DDR_ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [LEN_WIDTH-1:0]      len_a  [NUM_REQ];
  logic                      win_found;
  logic [IDX_W-1:0]          win_idx;
  logic [IDX_W-1:0]          cand;

  // Unpack the per-requester address/length slices.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_a[i] = req_addr[i*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
      len_a[i]  = req_len[i*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo four.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'(rr_ptr_q + IDX_W'(k));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = '0;
    done_d        = '0;
    cmd_valid_d   = cmd_valid_q;
    cmd_type_d    = cmd_type_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    timeout_err_d = timeout_err_q;
    rr_ptr_d      = rr_ptr_q;
    wd_d          = wd_q;

    case (state_q)
      IDLE: begin
        if (ddr_rdy && win_found) begin
          gnt_d[win_idx] = 1'b1;
          cmd_type_d     = win_idx;
          cmd_addr_d     = addr_a[win_idx];
          cmd_len_d      = len_a[win_idx];
          rr_ptr_d       = IDX_W'(win_idx + IDX_W'(1));
          wd_d           = '0;
          // A zero-length request completes without touching the DDR interface.
          if (len_a[win_idx] == '0) begin
            state_d = RELEASE;
          end else begin
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        wd_d = wd_q + TO_WIDTH'(1);
        if (cmd_ack) begin
          cmd_valid_d = 1'b0;
          wd_d        = '0;
          state_d     = burst_finish ? RELEASE : WAIT;
        end else if (wd_q == TO_LAST) begin
          cmd_valid_d   = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = RELEASE;
        end
      end
      WAIT: begin
        wd_d = wd_q + TO_WIDTH'(1);
        if (burst_finish) begin
          state_d = RELEASE;
        end else if (wd_q == TO_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = RELEASE;
        end
      end
      RELEASE: begin
        done_d[cmd_type_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      done_q        <= '0;
      busy_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_type_q    <= '0;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_type_q    <= cmd_type_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      timeout_err_q <= timeout_err_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_q          <= wd_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_type    = cmd_type_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_len     = cmd_len_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed bench for ddr_req_arbiter: per-cycle vector table plus hand sequences
// for the long-latency burst, round-robin rotation and watchdog abort.
module tb_ddr_req_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned LW = 10;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic          ddr_rdy = 1'b0;
  logic [3:0]    req = '0;
  logic [4*AW-1:0] req_addr;
  logic [4*LW-1:0] req_len;
  logic [3:0]    gnt, done;
  logic          busy, cmd_valid, cmd_ack = 1'b0, burst_finish = 1'b0, timeout_err;
  logic [1:0]    cmd_type;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;

  int n_vec = 0;
  int n_bad = 0;

  ddr_req_arbiter #(
    .DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .NUM_REQ(4),
    .TIMEOUT_CYCLES(16), .TO_WIDTH(5)
  ) dut (
    .mem_clk(mem_clk), .rst(rst), .ddr_rdy(ddr_rdy), .req(req),
    .req_addr(req_addr), .req_len(req_len), .gnt(gnt), .done(done),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ack(cmd_ack),
    .burst_finish(burst_finish), .timeout_err(timeout_err)
  );

  always #5 mem_clk = ~mem_clk;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [3:0] req;
    logic       ack;
    logic       fin;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic       cv;
    logic [1:0] typ;
    logic       terr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic rd, input logic [3:0] rq,
                              input logic a, input logic f, input logic [3:0] g,
                              input logic [3:0] d, input logic b, input logic c,
                              input logic [1:0] t, input logic e);
    vec_t v;
    v.rst = r; v.rdy = rd; v.req = rq; v.ack = a; v.fin = f;
    v.gnt = g; v.done = d; v.busy = b; v.cv = c; v.typ = t; v.terr = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int idx);
    logic [3:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Wait (bounded) for any grant and compare it to the expected requester.
  task automatic wait_gnt(input string name, input int exp_idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (gnt != 4'b0) seen = 1'b1;
    end
    check({name, " seen"}, 32'(seen), 32'd1);
    check({name, " gnt"}, 32'(gnt), 32'(onehot(exp_idx)));
  endtask

  initial begin
    logic [12:0] act, exp;
    int n;
    bit hit;

    req_addr = {28'h0ABCDE0, 28'h0200000, 28'h0008000, 28'h0001000};
    req_len  = {10'd32, 10'd0, 10'd17, 10'd8};

    // Fields: rst rdy req ack fin | gnt done busy cv typ terr
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 4'b0001, 4'b0000, 1, 1, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 1, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 1, 0, 4'b0000, 4'b0000, 1, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 0, 1, 4'b0000, 4'b0000, 1, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 4'b0000, 4'b0001, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));
    // zero-length request on slot 2; ack/finish during RELEASE are ignored
    tbl.push_back(mk(0, 1, 4'b0100, 0, 0, 4'b0100, 4'b0000, 1, 0, 2'd2, 0));
    tbl.push_back(mk(0, 1, 4'b0100, 1, 1, 4'b0000, 4'b0100, 0, 0, 2'd2, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd2, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 2'd2, 0));
    // slot 3 burst reset four cycles into WAIT
    tbl.push_back(mk(0, 1, 4'b1000, 0, 0, 4'b1000, 4'b0000, 1, 1, 2'd3, 0));
    tbl.push_back(mk(0, 1, 4'b1000, 1, 0, 4'b0000, 4'b0000, 1, 0, 2'd3, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 4'b1000, 0, 0, 4'b0000, 4'b0000, 1, 0, 2'd3, 0));
    tbl.push_back(mk(1, 1, 4'b1000, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));
    // slot 0 after reset; req dropped after grant, ack+finish together
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 4'b0001, 4'b0000, 1, 1, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 1, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 1, 1, 4'b0000, 4'b0000, 1, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0001, 0, 0, 2'd0, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 2'd0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; ddr_rdy = tbl[i].rdy; req = tbl[i].req;
      cmd_ack = tbl[i].ack; burst_finish = tbl[i].fin;
      step();
      act = {gnt, done, busy, cmd_valid, cmd_type, timeout_err};
      exp = {tbl[i].gnt, tbl[i].done, tbl[i].busy, tbl[i].cv, tbl[i].typ, tbl[i].terr};
      check($sformatf("vec[%0d]", i), 32'(act), 32'(exp));
    end
    cmd_ack = 1'b0; burst_finish = 1'b0;

    // Slot 1: ack three cycles after grant, finish arrives in the last watchdog cycle.
    req = 4'b0010;
    step();
    check("s1 gnt", 32'(gnt), 32'h2);
    check("s1 type", 32'(cmd_type), 32'd1);
    check("s1 addr", 32'(cmd_addr), 32'h0008000);
    check("s1 len", 32'(cmd_len), 32'd17);
    step(); step();
    check("s1 cv held", 32'(cmd_valid), 32'd1);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    check("s1 cv drop", 32'(cmd_valid), 32'd0);
    repeat (15) step();
    check("s1 busy wait", 32'(busy), 32'd1);
    burst_finish = 1'b1;
    step();
    burst_finish = 1'b0;
    req = 4'b0000;
    check("s1 fin prio", 32'(timeout_err), 32'd0);
    check("s1 no early done", 32'(done), 32'd0);
    step();
    check("s1 done", 32'(done), 32'h2);
    check("s1 busy low", 32'(busy), 32'd0);

    // Round-robin rotation with everyone requesting.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2 state", 32'({gnt, done, busy, cmd_valid, cmd_addr}), 32'd0);
    req_len[2*LW +: LW] = 10'd4;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt($sformatf("rr%0d", k), k % 4);
      cmd_ack = 1'b1;
      step();
      cmd_ack = 1'b0;
      repeat (4) step();
      burst_finish = 1'b1;
      step();
      burst_finish = 1'b0;
      if (k == 4) req = 4'b0000;
      step();
      check($sformatf("rr%0d done", k), 32'(done), 32'(onehot(k % 4)));
    end
    req_len[2*LW +: LW] = 10'd0;
    step();

    // Slot 3: ack then no finish; watchdog aborts after 16 WAIT cycles.
    req = 4'b1000;
    step();
    check("to gnt", 32'(gnt), 32'h8);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      n++;
      if (timeout_err) hit = 1'b1;
    end
    req = 4'b0000;
    check("to cycles", 32'(n), 32'd16);
    check("to no done yet", 32'(done), 32'd0);
    step();
    check("to done", 32'(done), 32'h8);

    // Normal slot 0 burst afterwards: error flag stays sticky.
    req = 4'b0001;
    step();
    check("post gnt", 32'(gnt), 32'h1);
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    burst_finish = 1'b1;
    step();
    burst_finish = 1'b0;
    req = 4'b0000;
    step();
    check("post done", 32'(done), 32'h1);
    check("post terr sticky", 32'(timeout_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
